// File: rtl/sram8_word_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram8_word_arbiter_if
// Description : Bus bundle for the sram8 word arbiter: CPU word port,
//               loader byte port and the attached sram8 port.
// Revision    : 1.0  initial release
// ============================================================================
interface sram8_word_arbiter_if #(
    parameter int SRAM_ADDR_WIDTH = 13
) ();
    // CPU word port
    logic                       cpu_valid;
    logic                       cpu_ready;
    logic [SRAM_ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]                cpu_wdata;
    logic [3:0]                 cpu_wstrb;
    logic [31:0]                cpu_rdata;
    // Loader byte port
    logic                       ld_valid;
    logic                       ld_ready;
    logic                       ld_wre;
    logic [SRAM_ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]                 ld_wdata;
    logic [7:0]                 ld_rdata;
    // sram8 side
    logic                       sram_ce;
    logic                       sram_wre;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic [7:0]                 sram_wdata;
    logic [7:0]                 sram_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        input  ld_valid, ld_wre, ld_addr, ld_wdata,
        input  sram_rdata,
        output cpu_ready, cpu_rdata, ld_ready, ld_rdata,
        output sram_ce, sram_wre, sram_addr, sram_wdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        output ld_valid, ld_wre, ld_addr, ld_wdata,
        output sram_rdata,
        input  cpu_ready, cpu_rdata, ld_ready, ld_rdata,
        input  sram_ce, sram_wre, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram8_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram8_word_arbiter
// Description : Round-robin share of one byte-wide sram8 between a 32-bit
//               CPU port (four byte slots per word) and a byte loader port.
// Revision    : 1.0  initial release
// ============================================================================
module sram8_word_arbiter #(
    parameter int SRAM_ADDR_WIDTH = 13
) (
    input  logic                clk,
    input  logic                reset_n,
    sram8_word_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_BYTE = 3'd1,
        S_LD_BYTE  = 3'd2,
        S_CAPTURE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [1:0]                 r_idx;
    logic [1:0]                 w_idx_nxt;
    logic                       r_owner_cpu;
    logic                       r_last_cpu;
    logic [SRAM_ADDR_WIDTH-1:0] r_addr;
    logic [3:0][7:0]            r_wdata;
    logic [3:0]                 r_wstrb;
    logic                       r_ld_wre;
    logic [23:0]                r_rd_buf;
    logic [31:0]                r_cpu_rdata;
    logic [7:0]                 r_ld_rdata;
    logic                       w_grant_cpu;
    logic                       w_grant_ld;
    logic                       w_cpu_write;

    assign w_cpu_write = |r_wstrb;

    // On a tie the port that did not win last time is granted.
    assign w_grant_cpu = (r_state == S_IDLE) && bus.cpu_valid &&
                         (!bus.ld_valid || !r_last_cpu);
    assign w_grant_ld  = (r_state == S_IDLE) && bus.ld_valid && !w_grant_cpu;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_grant_cpu) begin
                    w_state_nxt = S_CPU_BYTE;
                    w_idx_nxt   = 2'd0;
                end else if (w_grant_ld) begin
                    w_state_nxt = S_LD_BYTE;
                end
            end
            S_CPU_BYTE: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = w_cpu_write ? S_DONE : S_CAPTURE;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
            S_LD_BYTE: w_state_nxt = r_ld_wre ? S_DONE : S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // sram drive depends on registered state only, so reset blanks it at once.
    always_comb begin
        bus.sram_ce    = 1'b0;
        bus.sram_wre   = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = 8'd0;
        case (r_state)
            S_CPU_BYTE: begin
                bus.sram_addr  = {r_addr[SRAM_ADDR_WIDTH-1:2], r_idx};
                bus.sram_wdata = r_wdata[r_idx];
                if (w_cpu_write) begin
                    bus.sram_ce  = r_wstrb[r_idx];
                    bus.sram_wre = r_wstrb[r_idx];
                end else begin
                    bus.sram_ce  = 1'b1;
                end
            end
            S_LD_BYTE: begin
                bus.sram_ce    = 1'b1;
                bus.sram_wre   = r_ld_wre;
                bus.sram_addr  = r_addr;
                bus.sram_wdata = r_wdata[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner_cpu <= 1'b0;
            r_last_cpu  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= 4'd0;
            r_ld_wre    <= 1'b0;
        end else if (w_grant_cpu) begin
            r_owner_cpu <= 1'b1;
            r_last_cpu  <= 1'b1;
            r_addr      <= bus.cpu_addr;
            r_wdata     <= bus.cpu_wdata;
            r_wstrb     <= bus.cpu_wstrb;
            r_ld_wre    <= 1'b0;
        end else if (w_grant_ld) begin
            r_owner_cpu <= 1'b0;
            r_last_cpu  <= 1'b0;
            r_addr      <= bus.ld_addr;
            r_wdata     <= {24'd0, bus.ld_wdata};
            r_wstrb     <= 4'd0;
            r_ld_wre    <= bus.ld_wre;
        end
    end

    // sram data lags its issue slot by one cycle; bytes 0..2 land in a
    // shadow buffer so the visible cpu_rdata only changes at completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_buf    <= 24'd0;
            r_cpu_rdata <= 32'd0;
            r_ld_rdata  <= 8'd0;
        end else begin
            if (r_state == S_CPU_BYTE && !w_cpu_write) begin
                case (r_idx)
                    2'd1:    r_rd_buf[7:0]   <= bus.sram_rdata;
                    2'd2:    r_rd_buf[15:8]  <= bus.sram_rdata;
                    2'd3:    r_rd_buf[23:16] <= bus.sram_rdata;
                    default: ;
                endcase
            end
            if (r_state == S_CAPTURE) begin
                if (r_owner_cpu) begin
                    r_cpu_rdata <= {bus.sram_rdata, r_rd_buf};
                end else begin
                    r_ld_rdata <= bus.sram_rdata;
                end
            end
        end
    end

    assign bus.cpu_ready = (r_state == S_DONE) && r_owner_cpu;
    assign bus.ld_ready  = (r_state == S_DONE) && !r_owner_cpu;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ld_rdata  = r_ld_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram8_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram8_word_arbiter
// Description : Directed plus random bench for sram8_word_arbiter with a
//               transaction-level memory/arbitration reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram8_word_arbiter;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sram8_word_arbiter_if #(.SRAM_ADDR_WIDTH(AW)) bus ();

    sram8_word_arbiter #(.SRAM_ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Attached sram8: registered read data, contents survive reset.
    bit [7:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.sram_ce) begin
            if (bus.sram_wre) sram_mem[bus.sram_addr] <= bus.sram_wdata;
            else              bus.sram_rdata          <= sram_mem[bus.sram_addr];
        end
    end

    // Reference model state
    bit [7:0]    ref_mem [0:(1<<AW)-1];
    bit          m_last_cpu;
    logic [31:0] m_cpu_rdata;
    logic [7:0]  m_ld_rdata;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_cpu(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] st);
        int base;
        base = int'(a) & ~3;
        for (int i = 0; i < 4; i++) begin
            if (st == 4'd0) m_cpu_rdata[8*i +: 8] = ref_mem[base + i];
            else if (st[i]) ref_mem[base + i] = wd[8*i +: 8];
        end
    endtask

    task automatic model_ld(input logic [AW-1:0] a, input bit w, input logic [7:0] wd);
        if (w) ref_mem[int'(a)] = wd;
        else   m_ld_rdata = ref_mem[int'(a)];
    endtask

    task automatic model_reset();
        m_last_cpu  = 1'b0;
        m_cpu_rdata = 32'd0;
        m_ld_rdata  = 8'd0;
    endtask

    // One arbitration round: either or both ports raise valid together.
    task automatic run(input bit go_c, input bit go_l,
                       input logic [AW-1:0] ca, input logic [31:0] cw, input logic [3:0] cs,
                       input logic [AW-1:0] la, input bit lw, input logic [7:0] lwd,
                       input string tag);
        bit         first_c;
        int         lat_c, lat_l, exp_c, exp_l, got_c, got_l, spurious, s;
        int         ce_arr [64];
        int         addr_arr [64];
        logic [3:0] pat;
        first_c = go_c && (!go_l || !m_last_cpu);
        lat_c   = (cs == 4'd0) ? 6 : 5;
        lat_l   = lw ? 2 : 3;
        exp_c   = first_c ? lat_c : lat_l + 1 + lat_c;
        exp_l   = (go_c && first_c) ? lat_c + 1 + lat_l : lat_l;
        if (first_c) begin
            model_cpu(ca, cw, cs);
            if (go_l) model_ld(la, lw, lwd);
        end else begin
            if (go_l) model_ld(la, lw, lwd);
            if (go_c) model_cpu(ca, cw, cs);
        end
        if (go_c && go_l) m_last_cpu = !first_c;
        else if (go_c)    m_last_cpu = 1'b1;
        else if (go_l)    m_last_cpu = 1'b0;

        bus.cpu_valid = go_c; bus.cpu_addr = ca; bus.cpu_wdata = cw; bus.cpu_wstrb = cs;
        bus.ld_valid  = go_l; bus.ld_addr  = la; bus.ld_wre    = lw; bus.ld_wdata  = lwd;
        got_c = 0; got_l = 0; spurious = 0;
        for (int cyc = 1; cyc < 48; cyc++) begin
            @(posedge clk); #1;
            ce_arr[cyc]   = int'(bus.sram_ce);
            addr_arr[cyc] = int'(bus.sram_addr);
            if (bus.cpu_ready) begin
                if (!go_c || got_c != 0) spurious++;
                else begin
                    got_c = cyc;
                    check({tag, "/cpu_rdata"}, bus.cpu_rdata, m_cpu_rdata);
                    bus.cpu_valid = 1'b0;
                end
            end
            if (bus.ld_ready) begin
                if (!go_l || got_l != 0) spurious++;
                else begin
                    got_l = cyc;
                    check({tag, "/ld_rdata"}, 32'(bus.ld_rdata), 32'(m_ld_rdata));
                    bus.ld_valid = 1'b0;
                end
            end
            if ((!go_c || got_c != 0) && (!go_l || got_l != 0)) break;
        end
        bus.cpu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        if (go_c) check({tag, "/cpu_lat"}, 32'(got_c), 32'(exp_c));
        if (go_l) check({tag, "/ld_lat"}, 32'(got_l), 32'(exp_l));
        check({tag, "/spurious_ready"}, 32'(spurious), 32'd0);
        check({tag, "/cpu_rdata_hold"}, bus.cpu_rdata, m_cpu_rdata);
        check({tag, "/ld_rdata_hold"}, 32'(bus.ld_rdata), 32'(m_ld_rdata));
        if (go_c) begin
            s = first_c ? 1 : lat_l + 2;
            for (int i = 0; i < 4; i++) pat[i] = (ce_arr[s + i] != 0);
            check({tag, "/ce_slots"}, 32'(pat), 32'((cs == 4'd0) ? 4'hF : cs));
            check({tag, "/addr_slot3"}, 32'(addr_arr[s + 3]), 32'({ca[AW-1:2], 2'b11}));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.cpu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int          mode;
        bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 32'd0; bus.cpu_wstrb = 4'd0;
        bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_wre    = 1'b0;  bus.ld_wdata  = 8'd0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst/cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst/ld_ready", 32'(bus.ld_ready), 32'd0);
        check("rst/cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst/ld_rdata", 32'(bus.ld_rdata), 32'd0);
        check("rst/sram_ce", 32'(bus.sram_ce), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Loader fills 0x10..0x13, CPU reads the word back.
        for (int i = 0; i < 4; i++)
            run(0, 1, '0, 32'd0, 4'd0, AW'(16 + i), 1'b1, 8'(17 * (i + 1)), "t1_ldwr");
        run(1, 0, 13'h10, 32'd0, 4'd0, '0, 1'b0, 8'd0, "t1_cpurd");
        check("t1_word", bus.cpu_rdata, 32'h44332211);

        // Partial-strobe CPU write.
        run(1, 0, 13'h20, 32'hDEADBEEF, 4'b0101, '0, 1'b0, 8'd0, "t2_wr");
        run(1, 0, 13'h20, 32'd0, 4'd0, '0, 1'b0, 8'd0, "t2_rd");
        check("t2_word", bus.cpu_rdata, 32'h00AD00EF);

        // Simultaneous requests right out of reset, twice.
        do_reset();
        run(1, 1, 13'h10, 32'd0, 4'd0, 13'h11, 1'b0, 8'd0, "t3a");
        run(1, 1, 13'h10, 32'd0, 4'd0, 13'h12, 1'b0, 8'd0, "t3b");

        // Reset asserted during the idx-2 slot of a full word write.
        bus.cpu_valid = 1'b1; bus.cpu_addr = 13'h40; bus.cpu_wdata = 32'hAABBCCDD; bus.cpu_wstrb = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("t4/pre_ce", 32'(bus.sram_ce), 32'd1);
        check("t4/pre_addr", 32'(bus.sram_addr), 32'h42);
        reset_n = 1'b0;
        #1;
        check("t4/sram_ce", 32'(bus.sram_ce), 32'd0);
        check("t4/sram_wre", 32'(bus.sram_wre), 32'd0);
        check("t4/sram_addr", 32'(bus.sram_addr), 32'd0);
        check("t4/sram_wdata", 32'(bus.sram_wdata), 32'd0);
        check("t4/cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("t4/cpu_rdata", bus.cpu_rdata, 32'd0);
        bus.cpu_valid = 1'b0;
        ref_mem[16'h40] = 8'hDD;
        ref_mem[16'h41] = 8'hCC;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run(1, 0, 13'h40, 32'd0, 4'd0, '0, 1'b0, 8'd0, "t4_rd");
        check("t4_word", bus.cpu_rdata, 32'h0000CCDD);

        // Last byte of the address space through the loader.
        run(0, 1, '0, 32'd0, 4'd0, 13'h1FFF, 1'b1, 8'h5A, "t5_wr");
        saved = bus.cpu_rdata;
        run(0, 1, '0, 32'd0, 4'd0, 13'h1FFF, 1'b0, 8'd0, "t5_rd");
        check("t5_ld", 32'(bus.ld_rdata), 32'h5A);
        check("t5_cpu_hold", bus.cpu_rdata, saved);

        // Random mix over a small window so reads hit earlier writes.
        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 2));
            run(mode != 1, mode != 0,
                AW'(256 + $urandom_range(0, 63)), $urandom,
                ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                AW'(256 + $urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
